// File: rtl/lc3_mem_pkg.sv
// Shared constants and decode types for the LC-3 memory responder.
// Device-register addresses and status bit positions live here.
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam int READY_BIT = 15;
    localparam int IE_BIT    = 14;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR,
        SEL_MCR,
        SEL_NONE
    } sel_e;

endpackage

// File: rtl/lc3_ram.sv
// Synchronous single-port word RAM, read-before-write.
// Contents are deliberately left unreset.
module lc3_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          din,
    output logic [15:0]          dout
);

    logic [15:0] mem [2**ADDR_BITS];

    // Read the old word and optionally write the new one on the same edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/lc3_memory.sv
// LC-3 memory responder: word RAM plus KBSR/KBDR/DSR/DDR device page.
// Define LC3_MCR_EN to add the machine control register at xFFFE.
module lc3_memory
    import lc3_mem_pkg::*;
#(
    parameter int          ADDR_BITS = 12,
    parameter logic [15:0] MMIO_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_addr,
    input  logic [15:0] memory_din,
    input  logic        memWE,
    output logic [15:0] memory_dout,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        halt
);

    sel_e        sel;
    logic [15:0] mmioRd;
    logic [15:0] mmioQ;
    logic        selRamQ;
    logic [15:0] ramDout;
    logic        ramWe;

    logic        kbsrReady;
    logic        kbsrIe;
    logic [15:0] kbdr;
    logic        dsrReady;
    logic        dsrBit14;
    logic [15:0] ddr;
    logic        dispValid;

    logic        kbdRead;
    logic        kbdCap;
    logic        ddrWr;
    logic        dispAck;

`ifdef LC3_MCR_EN
    logic [15:0] mcr;
    logic        haltQ;
`endif

    // Address decode: the whole range below the device page is RAM
    always_comb begin
        sel = SEL_NONE;
        if (memory_addr < MMIO_BASE) begin
            sel = SEL_RAM;
        end else if (memory_addr == KBSR_ADDR) begin
            sel = SEL_KBSR;
        end else if (memory_addr == KBDR_ADDR) begin
            sel = SEL_KBDR;
        end else if (memory_addr == DSR_ADDR) begin
            sel = SEL_DSR;
        end else if (memory_addr == DDR_ADDR) begin
            sel = SEL_DDR;
`ifdef LC3_MCR_EN
        end else if (memory_addr == MCR_ADDR) begin
            sel = SEL_MCR;
`endif
        end
    end

    // Device-register read mux; unmapped page addresses read zero
    always_comb begin
        mmioRd = 16'h0000;
        unique case (sel)
            SEL_KBSR: mmioRd = {kbsrReady, kbsrIe, 14'h0000};
            SEL_KBDR: mmioRd = kbdr;
            SEL_DSR:  mmioRd = {dsrReady, dsrBit14, 14'h0000};
            SEL_DDR:  mmioRd = ddr;
`ifdef LC3_MCR_EN
            SEL_MCR:  mmioRd = mcr;
`endif
            default:  mmioRd = 16'h0000;
        endcase
    end

    assign ramWe   = memWE && (sel == SEL_RAM);
    assign kbdRead = !memWE && (sel == SEL_KBDR);
    assign kbdCap  = kbd_valid && kbd_ready;
    assign ddrWr   = memWE && (sel == SEL_DDR) && dsrReady;
    assign dispAck = dispValid && disp_ready;

    lc3_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk (clk),
        .we  (ramWe),
        .addr(memory_addr[ADDR_BITS-1:0]),
        .din (memory_din),
        .dout(ramDout)
    );

    // Register the device read value and remember which source to return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selRamQ <= 1'b0;
            mmioQ   <= 16'h0000;
        end else begin
            selRamQ <= (sel == SEL_RAM);
            mmioQ   <= mmioRd;
        end
    end

    assign memory_dout = selRamQ ? ramDout : mmioQ;

    // Keyboard side: capture when empty, a KBDR read empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbsrReady <= 1'b0;
            kbsrIe    <= 1'b0;
            kbdr      <= 16'h0000;
        end else begin
            if (kbdCap) begin
                kbdr      <= {8'h00, kbd_data};
                kbsrReady <= 1'b1;
            end else if (kbdRead) begin
                kbsrReady <= 1'b0;
            end
            if (memWE && (sel == SEL_KBSR)) begin
                kbsrIe <= memory_din[IE_BIT];
            end
        end
    end

    assign kbd_ready = ~kbsrReady;

    // Display side: a DDR write while idle launches one character
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsrReady  <= 1'b1;
            dsrBit14  <= 1'b0;
            ddr       <= 16'h0000;
            dispValid <= 1'b0;
        end else begin
            if (ddrWr) begin
                ddr       <= memory_din;
                dispValid <= 1'b1;
                dsrReady  <= 1'b0;
            end else if (dispAck) begin
                dispValid <= 1'b0;
                dsrReady  <= 1'b1;
            end
            if (memWE && (sel == SEL_DSR)) begin
                dsrBit14 <= memory_din[IE_BIT];
            end
        end
    end

    assign disp_valid = dispValid;
    assign disp_data  = ddr[7:0];

`ifdef LC3_MCR_EN
    // Machine control: clearing the clock-enable bit halts until set again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcr   <= 16'h8000;
            haltQ <= 1'b0;
        end else if (memWE && (sel == SEL_MCR)) begin
            mcr   <= memory_din;
            haltQ <= ~memory_din[READY_BIT];
        end
    end

    assign halt = haltQ;
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_memory.sv
// Self-checking bench for lc3_memory: reference model plus directed vectors.
// Honours LC3_MCR_EN the same way the design does.
module tb_lc3_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memory_addr;
    logic [15:0] memory_din;
    logic        memWE;
    logic [15:0] memory_dout;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        halt;

    int vectors = 0;
    int miscompares = 0;
    logic chkOn = 1'b0;

    localparam logic [15:0] IDLE = 16'hFE08;

    lc3_memory dut (
        .clk        (clk),
        .rst        (rst),
        .memory_addr(memory_addr),
        .memory_din (memory_din),
        .memWE      (memWE),
        .memory_dout(memory_dout),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] mRam [4096];
    logic        mKrdy, mKie, mDrdy, mD14, mDv;
    logic [15:0] mKdr, mDdr, mMcr, eDout;

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic mHalt();
`ifdef LC3_MCR_EN
        return !mMcr[15];
`else
        return 1'b0;
`endif
    endfunction

    task automatic mReset();
        mKrdy = 0; mKie = 0; mKdr = 0;
        mDrdy = 1; mD14 = 0; mDdr = 0; mDv = 0;
        mMcr = 16'h8000; eDout = 0;
    endtask

    function automatic logic [15:0] mRead(input logic [15:0] a);
        if (a < 16'hFE00) return mRam[a[11:0]];
        case (a)
            16'hFE00: return {mKrdy, mKie, 14'h0};
            16'hFE02: return mKdr;
            16'hFE04: return {mDrdy, mD14, 14'h0};
            16'hFE06: return mDdr;
`ifdef LC3_MCR_EN
            16'hFFFE: return mMcr;
`endif
            default:  return 16'h0000;
        endcase
    endfunction

    // One bus cycle of the memory-map rules, evaluated on pre-edge state
    task automatic mStep(input logic [15:0] a, input logic [15:0] d,
                         input logic w, input logic kv,
                         input logic [7:0] kd, input logic dr);
        logic kr, dv;
        kr = !mKrdy;
        dv = mDv;
        eDout = mRead(a);
        if (a < 16'hFE00) begin
            if (w) mRam[a[11:0]] = d;
        end else if (w && a == 16'hFE00) begin
            mKie = d[14];
        end else if (w && a == 16'hFE04) begin
            mD14 = d[14];
        end else if (w && a == 16'hFE06 && mDrdy) begin
            mDdr = d; mDv = 1; mDrdy = 0;
`ifdef LC3_MCR_EN
        end else if (w && a == 16'hFFFE) begin
            mMcr = d;
`endif
        end
        if (kv && kr) begin
            mKdr = {8'h00, kd}; mKrdy = 1;
        end else if (!w && a == 16'hFE02) begin
            mKrdy = 0;
        end
        if (dv && dr) begin
            mDv = 0; mDrdy = 1;
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chkOn) begin
            chk16("dout", memory_dout, eDout);
            chk16("kbd_ready", {15'h0, kbd_ready}, {15'h0, !mKrdy});
            chk16("disp_valid", {15'h0, disp_valid}, {15'h0, mDv});
            chk16("disp_data", {8'h0, disp_data}, {8'h0, mDdr[7:0]});
            chk16("halt", {15'h0, halt}, {15'h0, mHalt()});
        end
    end

    task automatic cyc(input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic kv,
                       input logic [7:0] kd, input logic dr);
        @(negedge clk);
        #1;
        memory_addr = a; memory_din = d; memWE = w;
        kbd_valid = kv; kbd_data = kd; disp_ready = dr;
        mStep(a, d, w, kv, kd, dr);
    endtask

    task automatic idle();
        cyc(IDLE, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        memory_addr = IDLE; memory_din = 0; memWE = 0;
        kbd_valid = 0; kbd_data = 0; disp_ready = 0;
        mReset();
        #1;
        chk16("rst_dout", memory_dout, 16'h0000);
        chk16("rst_disp_valid", {15'h0, disp_valid}, 16'h0000);
        chk16("rst_kbd_ready", {15'h0, kbd_ready}, 16'h0001);
        chk16("rst_halt", {15'h0, halt}, 16'h0000);
        @(negedge clk);
        #1;
        rst = 1'b0;
        chkOn = 1'b1;

        cyc(16'hFE04, 0, 0, 0, 0, 0); settle();
        chk16("rst_dsr", memory_dout, 16'h8000);
        cyc(16'hFE00, 0, 0, 0, 0, 0); settle();
        chk16("rst_kbsr", memory_dout, 16'h0000);

        // RAM and aliasing
        cyc(16'h3000, 16'hBEEF, 1, 0, 0, 0);
        cyc(16'h3000, 0, 0, 0, 0, 0); settle();
        chk16("ram_rd", memory_dout, 16'hBEEF);
        cyc(16'h4000, 0, 0, 0, 0, 0); settle();
        chk16("ram_alias", memory_dout, 16'hBEEF);
        cyc(16'h0005, 16'h1234, 1, 0, 0, 0);
        cyc(16'h0005, 16'h5678, 1, 0, 0, 0); settle();
        chk16("ram_rbw", memory_dout, 16'h1234);
        cyc(16'h0005, 0, 0, 0, 0, 0);
        cyc(IDLE, 16'hFFFF, 1, 0, 0, 0);
        cyc(IDLE, 0, 0, 0, 0, 0); settle();
        chk16("unmapped", memory_dout, 16'h0000);

        // Keyboard capture
        cyc(IDLE, 0, 0, 1, 8'h41, 0); settle();
        chk16("kbd_full", {15'h0, kbd_ready}, 16'h0000);
        cyc(16'hFE00, 0, 0, 0, 0, 0); settle();
        chk16("kbsr_set", memory_dout, 16'h8000);
        cyc(16'hFE02, 0, 0, 0, 0, 0); settle();
        chk16("kbdr_41", memory_dout, 16'h0041);
        chk16("kbd_empty", {15'h0, kbd_ready}, 16'h0001);
        cyc(16'hFE00, 0, 0, 0, 0, 0); settle();
        chk16("kbsr_clr", memory_dout, 16'h0000);

        // Keyboard overrun
        cyc(IDLE, 0, 0, 1, 8'h41, 0);
        cyc(16'hFE00, 0, 0, 1, 8'h42, 0);
        cyc(16'hFE00, 0, 0, 1, 8'h42, 0);
        cyc(16'hFE02, 0, 0, 1, 8'h42, 0); settle();
        chk16("ovr_kbdr", memory_dout, 16'h0041);
        cyc(16'hFE00, 0, 0, 1, 8'h42, 0); settle();
        chk16("ovr_kbsr", memory_dout, 16'h0000);
        chk16("ovr_full", {15'h0, kbd_ready}, 16'h0000);
        cyc(16'hFE02, 0, 0, 0, 0, 0); settle();
        chk16("ovr_42", memory_dout, 16'h0042);

        // KBSR interrupt-enable is writable, ready is not
        cyc(16'hFE00, 16'hC000, 1, 0, 0, 0);
        cyc(16'hFE00, 0, 0, 0, 0, 0); settle();
        chk16("kbsr_ie", memory_dout, 16'h4000);

        // Display
        cyc(16'hFE06, 16'h0048, 1, 0, 0, 0); settle();
        chk16("disp_v1", {15'h0, disp_valid}, 16'h0001);
        chk16("disp_d48", {8'h0, disp_data}, 16'h0048);
        cyc(16'hFE04, 0, 0, 0, 0, 0); settle();
        chk16("dsr_busy", memory_dout, 16'h0000);
        cyc(16'hFE06, 16'h0049, 1, 0, 0, 0); settle();
        chk16("disp_keep", {8'h0, disp_data}, 16'h0048);
        cyc(IDLE, 0, 0, 0, 0, 1); settle();
        chk16("disp_ack", {15'h0, disp_valid}, 16'h0000);
        cyc(16'hFE04, 0, 0, 0, 0, 0); settle();
        chk16("dsr_idle", memory_dout, 16'h8000);

        // Reset mid-transfer
        cyc(16'hFE06, 16'h0055, 1, 1, 8'h43, 0);
        cyc(16'hFE00, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        memory_addr = IDLE; memWE = 0; kbd_valid = 0;
        rst = 1'b1;
        mReset();
        #1;
        chk16("mid_dout", memory_dout, 16'h0000);
        chk16("mid_disp", {15'h0, disp_valid}, 16'h0000);
        chk16("mid_kbd", {15'h0, kbd_ready}, 16'h0001);
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc(16'hFE04, 0, 0, 0, 0, 0); settle();
        chk16("mid_dsr", memory_dout, 16'h8000);
        cyc(16'hFE00, 0, 0, 0, 0, 0); settle();
        chk16("mid_kbsr", memory_dout, 16'h0000);

        // Machine control register
`ifdef LC3_MCR_EN
        cyc(16'hFFFE, 16'h0000, 1, 0, 0, 0); settle();
        chk16("mcr_halt", {15'h0, halt}, 16'h0001);
        cyc(16'hFFFE, 0, 0, 0, 0, 0);
        idle(); settle();
        chk16("mcr_sticky", {15'h0, halt}, 16'h0001);
        cyc(16'hFFFE, 16'h8000, 1, 0, 0, 0); settle();
        chk16("mcr_run", {15'h0, halt}, 16'h0000);
        cyc(16'hFFFE, 0, 0, 0, 0, 0); settle();
        chk16("mcr_rd", memory_dout, 16'h8000);
`else
        cyc(16'hFFFE, 16'h0000, 1, 0, 0, 0); settle();
        chk16("nomcr_halt", {15'h0, halt}, 16'h0000);
        cyc(16'hFFFE, 0, 0, 0, 0, 0); settle();
        chk16("nomcr_rd", memory_dout, 16'h0000);
`endif

        idle();
        idle();
        @(negedge clk);
        #1;
        chkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lc3_memory.md
Name: lc3_memory

Overview:
- Memory-side responder for the LC-3 CPU memory port. The CPU drives address, write data and write enable; this block returns read data.
- Contains a single-port word RAM plus the standard LC-3 memory-mapped I/O registers: KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06.
- Bridges a keyboard input handshake and a display output handshake to the CPU address space.
- Sits beside the CPU core at the top level and replaces a bare behavioural RAM.

Parameters:
- ADDR_BITS, 12, RAM depth is 2**ADDR_BITS 16-bit words.
- MMIO_BASE, 16'hFE00, first address of the device-register page. Addresses >= MMIO_BASE never reach the RAM.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- memory_addr  input  16  word address from the CPU
- memory_din  input  16  write data from the CPU
- memWE  input  1  write strobe from the CPU
- memory_dout  output  16  read data to the CPU (registered)
- kbd_valid  input  1  keyboard has a character
- kbd_data  input  8  keyboard character
- kbd_ready  output  1  block can accept a character
- disp_valid  output  1  display character pending
- disp_data  output  8  display character
- disp_ready  input  1  display accepts a character
- halt  output  1  MCR clock-enable cleared (only with LC3_MCR_EN; otherwise tied 0)

Behaviour:
- Reset values:
  - memory_dout=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, disp_valid=0, halt=0.
  - RAM contents are not reset.
- Read:
  - memory_dout <= word at memory_addr on every rising edge, so there is 1-cycle latency.
  - The CPU holds the address for at least 2 cycles per access.
- Write:
  - When memWE=1, the selected location is written at the edge.
  - memory_dout that cycle shows the old contents (read-before-write).
- RAM decode:
  - Any address < MMIO_BASE selects RAM[memory_addr[ADDR_BITS-1:0]].
  - Upper bits are ignored, so addresses alias modulo the depth.
- MMIO decode:
  - Unmapped addresses in the MMIO page read 0; writes to them are ignored.
- KBSR:
  - Bit15 is the ready flag and is read-only to the CPU.
  - Bit14 is interrupt-enable and is CPU-writable.
  - All other bits read 0.
- Keyboard capture:
  - kbd_ready = ~KBSR[15] (combinational).
  - When kbd_valid & kbd_ready at an edge: KBDR <= {8'h00, kbd_data} and KBSR[15] <= 1.
- KBDR:
  - A read (memWE=0, addr=KBDR) clears KBSR[15] at that edge.
  - memory_dout returns the pre-clear KBDR value.
  - Writes to KBDR are ignored.
- Simultaneous KBDR read and kbd_valid:
  - No capture that cycle, because kbd_ready=0.
  - Capture occurs on the next edge at the earliest.
- DSR:
  - Bit15 is ready (1 = idle) and is read-only to the CPU.
  - Bit14 is CPU-writable.
- DDR write when DSR[15]=1:
  - DDR <= memory_din, disp_data <= memory_din[7:0], disp_valid <= 1, DSR[15] <= 0.
- DDR write when DSR[15]=0:
  - The write is ignored and the pending character is preserved.
- Display handshake:
  - When disp_valid & disp_ready at an edge: disp_valid <= 0 and DSR[15] <= 1.
  - disp_valid is registered, so the earliest acceptance is the edge after the DDR write.
- Reset mid-transfer:
  - Pending character dropped, disp_valid=0, DSR idle, captured keyboard character lost.

Optional Feature:
- LC3_MCR_EN defined:
  - Adds MCR at 16'hFFFE, reset value 16'h8000.
  - The CPU may write all bits.
  - halt = ~MCR[15], registered.
  - halt is sticky until reset or until the CPU writes 1 to bit15.
- LC3_MCR_EN undefined:
  - xFFFE is unmapped (reads 0), and halt is tied to 0.

Decomposition:
- Package lc3_mem_pkg holds:
  - Address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR.
  - Bit positions READY_BIT=15 and IE_BIT=14.
  - A decode enum: SEL_RAM, SEL_KBSR, SEL_KBDR, SEL_DSR, SEL_DDR, SEL_MCR, SEL_NONE.
- One sub-module, lc3_ram: synchronous single-port RAM (ADDR_BITS x 16, read-before-write). MMIO registers and decode stay in lc3_memory.

Test Plan:
- RAM write/read: write 16'hBEEF to x3000; read x3000 -> memory_dout=16'hBEEF one cycle later. Read x3000+2**ADDR_BITS -> 16'hBEEF (aliasing).
- Keyboard capture: kbd_valid=1, kbd_data=8'h41 -> KBSR reads 16'h8000, KBDR reads 16'h0041, kbd_ready=0. After the KBDR read, KBSR reads 0 and kbd_ready=1.
- Keyboard overrun: hold kbd_valid with 8'h42 while KBSR[15]=1 -> KBDR stays 16'h0041 until read; 8'h42 is captured the cycle after the read.
- Display: write 16'h0048 to DDR with disp_ready=0 -> disp_valid=1, disp_data=8'h48, DSR=0. A second write of 16'h0049 is ignored. Raise disp_ready -> disp_valid=0 and DSR=16'h8000 next cycle.
- Reset mid-transfer: assert rst while disp_valid=1 and KBSR[15]=1 -> disp_valid=0, DSR=16'h8000, KBSR=0, memory_dout=0 immediately (asynchronous).
- LC3_MCR_EN: write 16'h0000 to xFFFE -> halt=1 next cycle. Write 16'h8000 -> halt=0. Without the macro, halt stays 0 and xFFFE reads 0.
